palette_lookup_arbiter: RTL and testbench

PALETTE_LOOKUP_ARBITER -- requirements
Module: palette_lookup_arbiter

---
 rtl/pvz_palette_pkg.sv | 31 +++
 rtl/palette_regfile.sv | 27 ++
 rtl/palette_lookup_arbiter.sv | 101 ++++++++++
 tb/tb_palette_lookup_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pvz_palette_pkg.sv
// Shared palette types, the power-on background palette and the round-robin pointer helper.
package pvz_palette_pkg;

  localparam int unsigned PAL_DEPTH = 16;
  localparam int unsigned PAL_AW    = 4;

  typedef logic [11:0] rgb12_t;
  typedef rgb12_t palette_t [PAL_DEPTH];

  // Entry 0 first; these are the colours the background layer expects after reset.
  localparam palette_t DEFAULT_BG_PALETTE = '{
    12'h573, 12'hAA9, 12'h443, 12'hCCB,
    12'h998, 12'h783, 12'hBBA, 12'h322,
    12'h554, 12'hEEC, 12'hA75, 12'h787,
    12'h683, 12'h854, 12'h665, 12'h573
  };

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_split_t;

  function automatic logic [1:0] rr_next(input logic [1:0] id, input int unsigned num_req);
    int unsigned n;
    n = 32'(id) + 1;
    if (n >= num_req) n = 0;
    return 2'(n);
  endfunction

endpackage

// File: rtl/palette_regfile.sv
// 16 x 12-bit palette storage: synchronous write, asynchronous read, reset to the default palette.
module palette_regfile
  import pvz_palette_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [PAL_AW-1:0]  waddr_i,
  input  rgb12_t             wdata_i,
  input  logic [PAL_AW-1:0]  raddr_i,
  output rgb12_t             rdata_o
);

  palette_t mem_q;

  // Reset has priority, so a write presented during reset is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= DEFAULT_BG_PALETTE;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one palette read port among pixel requesters, one lookup per cycle.
module palette_lookup_arbiter
  import pvz_palette_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] index,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rgb_valid,
  output logic [1:0]           rgb_id,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [11:0]          cfg_data
);

  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic               grant_any;
  logic [1:0]         gnt_id;
  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] cand_oh;
  int unsigned        cand;
  logic [3:0]         sel_index;
  rgb12_t             rd_data;

  logic               rgb_valid_q;
  logic [1:0]         rgb_id_q;
  rgb_split_t         colour_q;

  // Walk upward from rr_ptr with wrap; the first requester found wins.
  always_comb begin
    grant_any = 1'b0;
    gnt_id    = '0;
    gnt_d     = '0;
    cand      = 0;
    cand_oh   = '0;
    if (!Reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_oh = NUM_REQ'(1) << cand;
        if (!grant_any && (|(req & cand_oh))) begin
          grant_any = 1'b1;
          gnt_id    = 2'(cand);
          gnt_d     = cand_oh;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = rr_next(gnt_id, NUM_REQ);
  end

  assign sel_index = 4'(index >> {gnt_id, 2'b00});
  assign gnt       = gnt_d;

  palette_regfile u_palette (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (sel_index),
    .rdata_o (rd_data)
  );

  // Colour and id only load on a grant, so idle cycles keep showing the last result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q    <= '0;
      rgb_valid_q <= 1'b0;
      rgb_id_q    <= '0;
      colour_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rgb_valid_q <= grant_any;
      if (grant_any) begin
        rgb_id_q <= gnt_id;
        colour_q <= rgb_split_t'(rd_data);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) assert ($onehot0(gnt) && ((gnt & ~req) == '0));
  end

  assign rgb_valid = rgb_valid_q;
  assign rgb_id    = rgb_id_q;
  assign red       = colour_q.red;
  assign green     = colour_q.green;
  assign blue      = colour_q.blue;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Scenario bench for palette_lookup_arbiter with a queue of expected lookup results.
module tb_palette_lookup_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  req;
  logic [11:0] index;
  logic [2:0]  gnt;
  logic        rgb_valid;
  logic [1:0]  rgb_id;
  logic [3:0]  red, green, blue;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;

  always #5 Clk = ~Clk;

  palette_lookup_arbiter #(.NUM_REQ(3)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .index     (index),
    .gnt       (gnt),
    .rgb_valid (rgb_valid),
    .rgb_id    (rgb_id),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] rgb;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] pal_m [16];
  logic [1:0]  last_id;
  logic [11:0] last_rgb;
  int          rr_m;
  int          checks = 0;
  int          errors = 0;

  task automatic init_pal();
    logic [11:0] tbl [16];
    tbl = '{12'h573, 12'hAA9, 12'h443, 12'hCCB, 12'h998, 12'h783, 12'hBBA, 12'h322,
            12'h554, 12'hEEC, 12'hA75, 12'h787, 12'h683, 12'h854, 12'h665, 12'h573};
    for (int i = 0; i < 16; i++) pal_m[i] = tbl[i];
  endtask

  // Called just after a falling edge with inputs already driven; consumes one clock cycle.
  task automatic step(input logic [2:0] exp_gnt);
    logic        was_reset;
    int          gid;
    exp_t        e;
    logic [11:0] got_rgb;
    was_reset = Reset;
    #1;
    checks++;
    if (gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt: got %b expected %b at %0t", gnt, exp_gnt, $time);
    end
    gid = -1;
    for (int i = 0; i < 3; i++) if (exp_gnt[i]) gid = i;
    if (!was_reset && gid >= 0) begin
      e.id  = 2'(gid);
      e.rgb = pal_m[index[4*gid +: 4]];
      sb.push_back(e);
      rr_m = (gid + 1) % 3;
    end
    if (!was_reset && cfg_we) pal_m[cfg_addr] = cfg_data;
    if (was_reset) begin
      rr_m = 0;
      init_pal();
    end
    @(posedge Clk);
    #1;
    got_rgb = {red, green, blue};
    if (was_reset) begin
      checks++;
      if (rgb_valid !== 1'b0 || rgb_id !== 2'd0 || got_rgb !== 12'h000) begin
        errors++;
        $display("FAIL reset_out: got v=%b id=%0d rgb=%h expected v=0 id=0 rgb=000 at %0t",
                 rgb_valid, rgb_id, got_rgb, $time);
      end
      last_id  = '0;
      last_rgb = '0;
      sb.delete();
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rgb_valid !== 1'b1 || rgb_id !== e.id || got_rgb !== e.rgb) begin
        errors++;
        $display("FAIL lookup: got v=%b id=%0d rgb=%h expected v=1 id=%0d rgb=%h at %0t",
                 rgb_valid, rgb_id, got_rgb, e.id, e.rgb, $time);
      end
      last_id  = e.id;
      last_rgb = e.rgb;
    end else begin
      checks++;
      if (rgb_valid !== 1'b0 || rgb_id !== last_id || got_rgb !== last_rgb) begin
        errors++;
        $display("FAIL idle_hold: got v=%b id=%0d rgb=%h expected v=0 id=%0d rgb=%h at %0t",
                 rgb_valid, rgb_id, got_rgb, last_id, last_rgb, $time);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; req = 3'b111; index = 12'h000;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'hFFF;
    step(3'b000);
    step(3'b000);
    Reset = 1'b0; req = 3'b000; cfg_we = 1'b0;
    step(3'b000);
  endtask

  task automatic test_rr_all();
    req = 3'b111; index = 12'h210;
    step(3'b001);
    step(3'b010);
    step(3'b100);
    step(3'b001);
    req = 3'b000;
    step(3'b000);
  endtask

  task automatic test_single();
    req = 3'b010; index = 12'h030;
    repeat (4) step(3'b010);
    req = 3'b000;
    step(3'b000);
  endtask

  task automatic test_cfg_bypass();
    req = 3'b010; index = 12'h030;
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'hF00;
    step(3'b010);
    cfg_we = 1'b0;
    step(3'b010);
    req = 3'b000;
    step(3'b000);
  endtask

  task automatic test_reset_mid();
    req = 3'b011; index = 12'h033;
    step(3'b001);
    Reset = 1'b1;
    step(3'b000);
    Reset = 1'b0;
    step(3'b001);
    step(3'b010);
    req = 3'b000;
    step(3'b000);
  endtask

  task automatic test_wrap();
    req = 3'b100; index = 12'h500;
    step(3'b100);
    req = 3'b101; index = 12'h507;
    step(3'b001);
    step(3'b100);
    req = 3'b000;
    step(3'b000);
  endtask

  task automatic test_idle_hold();
    req = 3'b001; index = 12'h009;
    step(3'b001);
    req = 3'b000;
    repeat (3) step(3'b000);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    int         c;
    for (int n = 0; n < 150; n++) begin
      req      = 3'($urandom_range(0, 7));
      index    = 12'($urandom);
      cfg_we   = 1'($urandom_range(0, 1));
      cfg_addr = 4'($urandom);
      cfg_data = 12'($urandom);
      exp = '0;
      for (int k = 0; k < 3; k++) begin
        c = (rr_m + k) % 3;
        if (exp == 3'b000 && req[c]) exp[c] = 1'b1;
      end
      step(exp);
    end
    req = 3'b000; cfg_we = 1'b0;
    step(3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; req = '0; index = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    rr_m = 0; last_id = '0; last_rgb = '0;
    init_pal();
    @(negedge Clk);
    test_reset();
    test_rr_all();
    test_single();
    test_cfg_bypass();
    test_reset_mid();
    test_wrap();
    test_idle_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
